// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-register bridge: FSM state encoding,
// position of the read/write flag in the command word and the word that is
// returned to the SPI master when a bus access times out.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Every bit of the timeout word is set, so the master reads back all ones.
  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  // The rw flag is the MSB of the command word: RW_BIT_POS = DATA_WIDTH-1.
  function automatic int rw_bit_pos(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Front end of the bridge: brings the raw chip-select pin into the clk domain
// and turns the SPI slave's rx_valid level into a one-cycle byte event that is
// only honoured while the synchronized chip select is active.
module spi_cs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic rx_valid,
  output logic cs_s,
  output logic cs_rise,
  output logic byte_evt
);

  logic cs_meta;
  logic cs_s_d;
  logic rx_valid_d;

  // Two-flop synchronizer for cs_n, preset to inactive so reset never looks like a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
      cs_s_d  <= 1'b1;
    end else begin
      cs_meta <= cs_n;
      cs_s    <= cs_meta;
      cs_s_d  <= cs_s;
    end
  end

  // Delayed copy of rx_valid used to find its rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_d <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
    end
  end

  assign cs_rise  = cs_s & ~cs_s_d;
  assign byte_evt = rx_valid & ~rx_valid_d & ~cs_s;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI frame to register-bus bridge. Each chip-select frame carries a command
// word {rw, addr} followed by a write-data word; it is turned into one bus
// access, and read data is handed back to the SPI slave for the next frame.
// Optional build macro SPI_REG_AUTOINC_EN: extra words in a write frame issue
// further writes to consecutive addresses (wrapping at the top of the map).
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-2:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  timeout_err
);

  localparam int AW       = DATA_WIDTH - 1;
  localparam int RW_POS   = rw_bit_pos(DATA_WIDTH);
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] tcnt;
  logic             cs_s;
  logic             cs_rise;
  logic             byte_evt;

  spi_cs_sync u_cs_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .rx_valid (rx_valid),
    .cs_s     (cs_s),
    .cs_rise  (cs_rise),
    .byte_evt (byte_evt)
  );

  assign busy = (state != ST_IDLE);

  // Frame sequencer: decodes command/data words, runs the bus handshake with a timeout and loads tx_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      tx_data     <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cs_s) begin
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (byte_evt) begin
            bus_addr <= rx_data[AW-1:0];
            bus_we   <= ~rx_data[RW_POS];
            if (rx_data[RW_POS]) begin
              bus_req <= 1'b1;
              tcnt    <= '0;
              state   <= ST_BUS;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (byte_evt) begin
            bus_wdata <= rx_data;
            bus_we    <= 1'b1;
            bus_req   <= 1'b1;
            tcnt      <= '0;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
`ifdef SPI_REG_AUTOINC_EN
          if (byte_evt) begin
            frame_err <= 1'b1;
          end
`endif
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              tx_data <= bus_rdata;
            end
            state <= ST_DONE;
          end else if (tcnt == CNT_LAST) begin
            bus_req     <= 1'b0;
            timeout_err <= 1'b1;
            tx_data     <= {DATA_WIDTH{TIMEOUT_FILL_BIT}};
            state       <= ST_DONE;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
`ifdef SPI_REG_AUTOINC_EN
          if (byte_evt && bus_we) begin
            bus_addr  <= bus_addr + AW'(1);
            bus_wdata <= rx_data;
            bus_req   <= 1'b1;
            tcnt      <= '0;
            state     <= ST_BUS;
          end else
`endif
          if (cs_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge (DATA_WIDTH 8, timeout 255).
module tb_spi_reg_bridge;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       bus_req;
  logic       bus_we;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       busy;
  logic       frame_err;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  // bus responder settings: ack after ack_delay request cycles, 0 = never
  int         ack_delay = 0;
  logic [7:0] rdata_val = 8'h00;
  int         req_cyc   = 0;

  // monitor state
  logic       req_prev  = 1'b0;
  int         cur_len   = 0;
  int         last_len  = 0;
  int         req_falls = 0;
  int         fe_cnt    = 0;
  logic [6:0] acc_addr[$];
  logic       acc_we[$];
  logic [7:0] acc_wdata[$];

  spi_reg_bridge #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-bus slave model driving ack on the falling edge
  always @(negedge clk) begin
    if (bus_req) begin
      req_cyc = req_cyc + 1;
      if (ack_delay > 0 && req_cyc == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata_val;
      end else begin
        bus_ack = 1'b0;
      end
    end else begin
      req_cyc = 0;
      bus_ack = 1'b0;
    end
  end

  // records every access, its request length and frame_err pulses
  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (bus_req && !req_prev) begin
      acc_addr.push_back(bus_addr);
      acc_we.push_back(bus_we);
      acc_wdata.push_back(bus_wdata);
      cur_len = 0;
    end
    if (bus_req) cur_len = cur_len + 1;
    if (!bus_req && req_prev) begin
      last_len  = cur_len;
      req_falls = req_falls + 1;
    end
    req_prev = bus_req;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sends one received word the way the SPI slave presents it
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic csLow();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csHigh();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic waitFalls(input int target, input int limit);
    int n = 0;
    while (req_falls < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (req_falls < target) checkOutput("wait_bus_done", 32'(req_falls), 32'(target));
  endtask

  initial begin
    int base;
    int fe_base;
    int falls_base;
    int n;
    rst_n     = 1'b0;
    cs_n      = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_bus_req", 32'(bus_req), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);

    // write frame 0x05, 0xA5
    ack_delay = 3;
    base = acc_addr.size(); fe_base = fe_cnt; falls_base = req_falls;
    csLow();
    applyStimulus(8'h05);
    applyStimulus(8'hA5);
    waitFalls(falls_base + 1, 50);
    csHigh();
    checkOutput("wr_count", 32'(acc_addr.size() - base), 32'd1);
    if (acc_addr.size() > base) begin
      checkOutput("wr_addr", 32'(acc_addr[base]), 32'h05);
      checkOutput("wr_we", 32'(acc_we[base]), 32'h1);
      checkOutput("wr_wdata", 32'(acc_wdata[base]), 32'hA5);
    end
    checkOutput("wr_frame_err", 32'(fe_cnt - fe_base), 32'd0);
    checkOutput("wr_timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("wr_tx_data", 32'(tx_data), 32'h00);
    checkOutput("wr_busy_after", 32'(busy), 32'h0);

    // read frame 0x83, 0x00 returning 0x3C
    ack_delay = 3; rdata_val = 8'h3C;
    base = acc_addr.size(); falls_base = req_falls;
    csLow();
    applyStimulus(8'h83);
    applyStimulus(8'h00);
    waitFalls(falls_base + 1, 50);
    csHigh();
    checkOutput("rd_count", 32'(acc_addr.size() - base), 32'd1);
    if (acc_addr.size() > base) begin
      checkOutput("rd_addr", 32'(acc_addr[base]), 32'h03);
      checkOutput("rd_we", 32'(acc_we[base]), 32'h0);
    end
    checkOutput("rd_tx_data", 32'(tx_data), 32'h3C);

    // next frame: tx_data still loaded at cs fall, then abort after command word
    base = acc_addr.size(); fe_base = fe_cnt;
    csLow();
    checkOutput("nf_tx_data", 32'(tx_data), 32'h3C);
    applyStimulus(8'h05);
    csHigh();
    checkOutput("abort_frame_err", 32'(fe_cnt - fe_base), 32'd1);
    checkOutput("abort_no_access", 32'(acc_addr.size() - base), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_tx_data", 32'(tx_data), 32'h3C);

    // read of 0x10 with no ack: timeout after 255 cycles
    ack_delay = 0;
    base = acc_addr.size(); falls_base = req_falls;
    csLow();
    applyStimulus(8'h90);
    waitFalls(falls_base + 1, 600);
    checkOutput("to_req_len", 32'(last_len), 32'd255);
    if (acc_addr.size() > base) begin
      checkOutput("to_addr", 32'(acc_addr[base]), 32'h10);
      checkOutput("to_we", 32'(acc_we[base]), 32'h0);
    end
    checkOutput("to_timeout_err", 32'(timeout_err), 32'h1);
    checkOutput("to_tx_data", 32'(tx_data), 32'hFF);
    csHigh();
    checkOutput("to_busy_after", 32'(busy), 32'h0);

    // write frame 0x7F, 0x11, 0x22
    ack_delay = 2;
    base = acc_addr.size(); fe_base = fe_cnt; falls_base = req_falls;
    csLow();
    applyStimulus(8'h7F);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (10) @(negedge clk);
    csHigh();
    checkOutput("ai_first_addr", 32'(acc_addr.size() > base ? acc_addr[base] : 7'h55), 32'h7F);
    checkOutput("ai_first_wdata", 32'(acc_wdata.size() > base ? acc_wdata[base] : 8'h55), 32'h11);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("ai_count", 32'(acc_addr.size() - base), 32'd2);
    if (acc_addr.size() > base + 1) begin
      checkOutput("ai_second_addr", 32'(acc_addr[base+1]), 32'h00);
      checkOutput("ai_second_wdata", 32'(acc_wdata[base+1]), 32'h22);
      checkOutput("ai_second_we", 32'(acc_we[base+1]), 32'h1);
    end
`else
    checkOutput("ai_count", 32'(acc_addr.size() - base), 32'd1);
`endif
    checkOutput("ai_frame_err", 32'(fe_cnt - fe_base), 32'd0);
    checkOutput("ai_timeout_sticky", 32'(timeout_err), 32'h1);
    checkOutput("ai_tx_data", 32'(tx_data), 32'hFF);

    // reset pulse while a read request is outstanding
    ack_delay = 0;
    csLow();
    applyStimulus(8'h81);
    n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mr_req_seen", 32'(bus_req), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mr_bus_req", 32'(bus_req), 32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h0);
    checkOutput("mr_tx_data", 32'(tx_data), 32'h00);
    checkOutput("mr_timeout_err", 32'(timeout_err), 32'h0);
    csHigh();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of the SPI slave. Consumes the slave's received byte and valid strobe and turns each chip-select frame into one register-bus access.
- Returns read data to the slave's transmit-load input, so the read result is shifted out on miso during the next frame.
- Frame format, MSB first:
  - Byte 0 = {rw, addr[DATA_WIDTH-2:0]}; rw = 1 means read.
  - Byte 1 = write data (write) or don't-care (read).

Parameters:
- DATA_WIDTH, 8, SPI word width; must be at least 4. The address width is DATA_WIDTH-1.
- TIMEOUT_CYCLES, 255, number of clk cycles to wait for bus_ack before aborting.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- cs_n  input  1  raw SPI chip select (asynchronous pin)
- rx_data  input  DATA_WIDTH  slave's received word
- rx_valid  input  1  slave's data-valid level (high from the last bit of a word until the next sample)
- tx_data  output  DATA_WIDTH  word the slave loads at cs_n fall
- bus_req  output  1  register access request
- bus_we  output  1  1 = write
- bus_addr  output  DATA_WIDTH-1  register address
- bus_wdata  output  DATA_WIDTH  write data
- bus_ack  input  1  one-cycle completion strobe
- bus_rdata  input  DATA_WIDTH  read data, valid with bus_ack
- busy  output  1  FSM not in IDLE
- frame_err  output  1  one-cycle pulse
- timeout_err  output  1  sticky; cleared only by reset

Behaviour:
- Reset (synchronous, rst_n = 0 sampled at clk):
  - tx_data = 0; bus_req, bus_we, bus_addr, bus_wdata = 0; frame_err = 0; timeout_err = 0.
  - FSM to IDLE; the cs_n synchronizer is preset to 1.
  - Reset asserted mid-access drops bus_req immediately, with no completion required.
- cs_n passes through a 2-flop synchronizer giving cs_s.
- A byte event is a rising edge of rx_valid, taken against a 1-flop delayed copy. Byte events count only while cs_s = 0.
- States and transitions:
  - IDLE: on cs_s = 0 go to CMD.
  - CMD: on a byte event, latch addr and rw.
    - Read: assert bus_req with bus_we = 0 on the next cycle, go to BUS.
    - Write: go to DATA.
    - cs_s = 1 before a byte: frame_err pulse, go to IDLE.
  - DATA: on a byte event, latch bus_wdata, assert bus_req with bus_we = 1, go to BUS.
    - cs_s = 1 before a byte: frame_err pulse, go to IDLE, no access.
  - BUS: bus_req, bus_we, bus_addr and bus_wdata are held stable until bus_ack or timeout.
    - On bus_ack: drop bus_req in the same cycle as the registered update. If read, tx_data <= bus_rdata. Go to DONE.
    - Timeout counter reaches TIMEOUT_CYCLES with no ack: drop bus_req, set timeout_err, tx_data <= all ones, go to DONE.
    - cs_s rising while in BUS does not abort the access; it completes first.
  - DONE: further byte events are ignored; go to IDLE when cs_s = 1.
- A byte event in BUS is dropped and pulses frame_err. This can only occur with the optional feature enabled.
- bus_ack outside BUS is ignored.
- tx_data changes only on ack or timeout. It is stable across any cs_n falling edge that did not follow an access in the same frame.
- Latency:
  - Byte event to bus_req = 1 cycle.
  - bus_ack to bus_req low = 1 cycle (registered).
  - The timeout counter is DATA_WIDTH-independent, sized by $clog2(TIMEOUT_CYCLES+1), and clears on entering BUS.

Optional Feature:
- SPI_REG_AUTOINC_EN defined: in a write frame, each byte event in DONE issues a further write.
  - Target address is the previous address + 1, wrapping from all ones to 0.
  - The FSM returns through BUS, then back to DONE.
  - Read frames are unchanged.
- Not defined: DONE ignores all bytes, so exactly one access per frame.

Decomposition:
- Shared package spi_pkg holds:
  - The FSM state encoding (IDLE, CMD, DATA, BUS, DONE).
  - RW_BIT_POS = DATA_WIDTH-1.
  - The timeout fill pattern (all ones).
- One natural sub-module, spi_cs_sync: the 2-flop cs_n synchronizer plus the rx_valid edge detector, producing cs_s, cs_rise and byte_evt.

Test Plan:
- Write frame 0x05, 0xA5, ack after 3 cycles -> one bus_req with we = 1, addr = 0x05, wdata = 0xA5; frame_err and timeout_err stay 0; tx_data unchanged.
- Read frame 0x83, 0x00, ack with rdata 0x3C -> bus_req with we = 0, addr = 0x03; tx_data = 0x3C after ack; the next frame's slave miso shifts 0x3C.
- cs_n rises after only the command byte of a write -> frame_err pulses once, no bus_req, FSM returns to IDLE.
- Read of addr 0x10 with bus_ack never asserted -> bus_req drops after 255 cycles, timeout_err = 1 (sticky), tx_data = 0xFF.
- rst_n low for 1 cycle while bus_req is high -> next cycle bus_req = 0, busy = 0, tx_data = 0, timeout_err = 0.
- With SPI_REG_AUTOINC_EN defined, write frame 0x7F, 0x11, 0x22 -> writes (0x7F, 0x11) then (0x00, 0x22).
- Without the macro, the same frame -> the third byte is ignored.
